idct_coeff_seq: RTL

IDCT_COEFF_SEQ -- requirements
Module: idct_coeff_seq

---
 rtl/idct_coeff_seq.sv | 88 ++++++++
 1 files changed

// File: rtl/idct_coeff_seq.sv
// idct_coeff_seq: streams the 8x8 IDCT cosine table as LANES-wide beats, column or transposed order.
// Define IDCT_SEQ_PARITY_EN to add a registered even-parity output over coef.
module idct_coeff_seq #(
   parameter int LANES  = 4,
   parameter int COEF_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    mode,
   input  logic                    ready,
   output logic                    valid,
   output logic [LANES*COEF_W-1:0] coef,
   output logic [2:0]              col,
   output logic [2:0]              base,
   output logic                    last,
   output logic                    busy,
   output logic                    done
`ifdef IDCT_SEQ_PARITY_EN
   ,
   output logic                    parity
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [2:0] LAST_BASE = 3'(8 - LANES);
   localparam logic [2:0] STEP = 3'(LANES);
   // Indexed by {frequency row i, sample j}; every entry fits 12-bit signed.
   localparam logic signed [11:0] TBL [64] = '{
      1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448,
      2008,  1702,  1137,   399,  -399, -1137, -1702, -2008,
      1892,   783,  -783, -1892, -1892,  -783,   783,  1892,
      1702,  -399, -2008, -1137,  1137,  2008,   399, -1702,
      1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448,
      1137, -2008,   399,  1702, -1702,  -399,  2008, -1137,
       783, -1892,  1892,  -783,  -783,  1892, -1892,   783,
       399, -1137,  1702, -2008,  2008, -1702,  1137,  -399
   };
   state_t state, state_n;
   logic mode_r, mode_n, adv, wrap, last_n;
   logic [2:0] col_n, base_n;
   logic [LANES*COEF_W-1:0] coef_n;
   function automatic logic [COEF_W-1:0] lut(input logic [2:0] r, input logic [2:0] c);
      return COEF_W'(TBL[{r, c}]);
   endfunction
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mode_r <= 1'b0;
         valid  <= 1'b0;
         coef   <= '0;
         col    <= 3'd0;
         base   <= 3'd0;
         last   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         mode_r <= mode_n;
         valid  <= state_n == RUN;
         coef   <= coef_n;
         col    <= col_n;
         base   <= base_n;
         last   <= last_n;
         busy   <= state_n != IDLE;
         done   <= state_n == DONE;
      end
   end
   always_comb begin
      adv     = state == RUN && ready;
      wrap    = base == LAST_BASE;
      state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (adv && last ? DONE : RUN) : IDLE;
      mode_n  = state == IDLE && start ? mode : mode_r;
   end
   // Outputs are precomputed from the next position so they register in step with state.
   always_comb begin
      base_n = state_n != RUN ? 3'd0 : adv ? (wrap ? 3'd0 : base + STEP) : base;
      col_n  = state_n != RUN ? 3'd0 : adv && wrap ? col + 3'd1 : col;
      last_n = state_n == RUN && col_n == 3'd7 && base_n == LAST_BASE;
      coef_n = '0;
      for (int l = 0; l < LANES; l++)
         coef_n[l*COEF_W +: COEF_W] = state_n != RUN ? '0 :
            mode_n ? lut(col_n, base_n + 3'(l)) : lut(base_n + 3'(l), col_n);
   end
`ifdef IDCT_SEQ_PARITY_EN
   always_ff @(posedge clk)
      parity <= rst ? 1'b0 : ^coef_n;
`endif
endmodule
